fifo_packer: RTL

- Upstream stage of the `fifo` buffer. It packs narrow valid/ready input beats into full-width words and drives the FIFO's push/data_in interface.
- It honours the FIFO's `full` flag, so `overflow` can never fire.
- `in_last` closes a word early, producing a partial word with a lane-valid mask.
- Used wherever a narrow producer (byte/halfword stream) feeds a wide FIFO.

---
 rtl/fifo_packer_if.sv | 42 ++++
 rtl/fifo_packer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_packer_if.sv
// fifo_packer_if: bundles the narrow input stream and the FIFO-facing push
// side of fifo_packer.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// in_ready never depends on in_valid. in_data and in_last matter only while
// in_valid is high. On the FIFO side, out_push is a single-cycle write strobe
// that is never raised while fifo_full is high. out_data, out_keep and
// out_last stay stable until the word has been pushed.
//
// Signals:
//   in_valid / in_ready / in_data / in_last : narrow producer stream
//   fifo_full                               : FIFO full flag
//   out_push / out_data / out_keep / out_last : FIFO write port plus sideband
// Modports:
//   slave  : the packer (consumes the stream, drives the FIFO write)
//   master : the environment (producer plus FIFO)
interface fifo_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 fifo_full;
  logic                 out_push;
  logic [OUT_WIDTH-1:0] out_data;
  logic [RATIO-1:0]     out_keep;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, out_push, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, out_push, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fifo_packer.sv
// fifo_packer: packs narrow IN_WIDTH beats into OUT_WIDTH words and pushes
// them into a FIFO.
//
// Beats fill lanes starting at lane 0, which is bits [IN_WIDTH-1:0]. A word
// completes when its last lane fills or when a beat carries in_last. A word
// closed early by in_last has its unused lanes zeroed, and out_keep marks the
// lanes that hold data. A completed word sits in a one-entry output register
// until the FIFO has room. The block never pushes while fifo_full is high.
//
// Ports:
//   clk     : clock
//   arst_n  : asynchronous active-low reset
//   init    : synchronous soft reset; drops the partial word and the pending word
//   bus     : fifo_packer_if.slave (input stream and FIFO write side)
//   busy    : a partial word or a pending output word is held
module fifo_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           init,
  fifo_packer_if.slave   bus,
  output logic           busy
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : g_param_check
    $error("fifo_packer: OUT_WIDTH must be a multiple of IN_WIDTH with at least two lanes");
  end

  logic [OUT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     lane_cnt;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic [RATIO-1:0]     out_keep_q;
  logic                 out_last_q;

  logic                 accept;
  logic                 word_done;
  logic                 push;
  logic [OUT_WIDTH-1:0] merged;
  logic [RATIO-1:0]     keep_next;

  // The output register may reload in the same cycle it drains, so in_ready
  // only drops when a word is stuck behind a full FIFO.
  assign bus.in_ready = !init && (!out_valid || !bus.fifo_full);
  assign push         = out_valid && !bus.fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign word_done    = accept && ((lane_cnt == LAST_LANE) || bus.in_last);

  assign bus.out_push = push;
  assign bus.out_data = out_data_q;
  assign bus.out_keep = out_keep_q;
  assign bus.out_last = out_last_q;
  assign busy         = (lane_cnt != '0) || out_valid;

  // The accumulator with the current beat inserted at lane_cnt. Lanes above
  // it are forced to zero so that an early-closed word carries no stale data.
  always_comb begin
    merged    = acc;
    keep_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) == lane_cnt) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end
      if (CNT_W'(i) > lane_cnt) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = '0;
      end else begin
        keep_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc        <= '0;
      lane_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (init) begin
      acc       <= '0;
      lane_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (word_done) begin
        // Load the output register. If it is draining this cycle, it is
        // overwritten, which keeps back-to-back words at full rate.
        out_data_q <= merged;
        out_keep_q <= keep_next;
        out_last_q <= bus.in_last;
        out_valid  <= 1'b1;
        acc        <= '0;
        lane_cnt   <= '0;
      end else begin
        if (accept) begin
          acc      <= merged;
          lane_cnt <= lane_cnt + CNT_W'(1);
        end
        if (push) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
